// File: rtl/ldpc_enc_ctrl.sv
// ldpc_enc_ctrl: frame sequencer in front of the 360-way LDPC parity encoder.
// Latency: last info bit accept edge to first parity m_valid edge = FLUSH_CYC+2.
// Backpressure: s_ready drops outside LOAD; m_* has no backpressure.
// Optional: define LDPC_SYS_OUT_EN to also forward info bits on m_* (systematic output).
module ldpc_enc_ctrl #(
  parameter int K_INFO    = 4320,
  parameter int P_BITS    = 360,
  parameter int CLR_CYC   = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic        s_data,
  input  logic        s_sop,
  output logic        s_ready,
  output logic        enc_rst_n,
  output logic        enc_din_valid,
  output logic        enc_din,
  output logic [12:0] enc_counter,
  output logic [8:0]  enc_out_addr,
  output logic        enc_check,
  input  logic        enc_dout,
  output logic        m_valid,
  output logic        m_data,
  output logic        m_sop,
  output logic        m_eop,
  output logic        busy,
  output logic        frame_err
);

  localparam logic [12:0] K_LAST     = 13'(K_INFO - 1);
  localparam logic [8:0]  P_LAST     = 9'(P_BITS - 1);
  localparam logic [1:0]  CLR_LAST   = 2'(CLR_CYC - 1);
  localparam logic [1:0]  FLUSH_LAST = 2'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    FLUSH  = 3'd3,
    PARITY = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [12:0] cnt;       // info bits accepted in the current frame
  logic [1:0]  tmr;       // dwell timer for CLEAR / FLUSH
  logic        check_d1;  // enc_check aligned with enc_dout
  logic [8:0]  addr_d1;   // enc_out_addr aligned with enc_dout
  logic        accept;
  logic        mid_sop;
  logic        last_bit;

  // A new sop while a frame is partly loaded restarts the frame.
  assign mid_sop  = (state == LOAD) && s_valid && s_sop && (cnt != 13'd0);
  assign accept   = s_valid && s_ready;
  assign last_bit = accept && (cnt == K_LAST);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid && s_sop)     state_nxt = CLEAR;
      CLEAR:   if (tmr == CLR_LAST)      state_nxt = LOAD;
      LOAD:    if (mid_sop)              state_nxt = CLEAR;
               else if (last_bit)        state_nxt = FLUSH;
      FLUSH:   if (tmr == FLUSH_LAST)    state_nxt = PARITY;
      PARITY:  if (enc_out_addr == 9'd0) state_nxt = DRAIN;
      DRAIN:                             state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // State-decoded control outputs.
  always_comb begin
    s_ready   = 1'b0;
    enc_rst_n = 1'b1;
    enc_check = 1'b0;
    case (state)
      CLEAR:   enc_rst_n = 1'b0;
      LOAD:    s_ready   = !mid_sop;
      PARITY:  enc_check = 1'b1;
      default: ;
    endcase
  end

  // Dwell timer restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  tmr <= 2'd0;
    else if (state_nxt != state) tmr <= 2'd0;
    else                         tmr <= tmr + 2'd1;
  end

  // Info path: register accepted bits onto the encoder input with their index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 13'd0;
      enc_din       <= 1'b0;
      enc_din_valid <= 1'b0;
      enc_counter   <= 13'd0;
      frame_err     <= 1'b0;
    end else begin
      enc_din_valid <= 1'b0;
      frame_err     <= mid_sop;
      if (state_nxt == CLEAR) begin
        cnt         <= 13'd0;
        enc_counter <= 13'd0;
      end else if (accept) begin
        cnt           <= cnt + 13'd1;
        enc_din       <= s_data;
        enc_din_valid <= 1'b1;
        enc_counter   <= cnt;
      end
    end
  end

  // Parity read address walks down from P_BITS-1 and reloads after the drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_addr <= P_LAST;
      check_d1     <= 1'b0;
      addr_d1      <= 9'd0;
    end else begin
      check_d1 <= enc_check;
      addr_d1  <= enc_out_addr;
      if (state == PARITY && enc_out_addr != 9'd0) enc_out_addr <= enc_out_addr - 9'd1;
      else if (state == DRAIN)                     enc_out_addr <= P_LAST;
    end
  end

  // Output stream: parity captured one cycle after its address (plus info bits if systematic).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 1'b0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
    end else begin
      m_valid <= check_d1;
      m_data  <= enc_dout;
      m_eop   <= check_d1 && (addr_d1 == 9'd0);
`ifdef LDPC_SYS_OUT_EN
      m_sop   <= 1'b0;
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_sop   <= (cnt == 13'd0);
        m_eop   <= 1'b0;
      end
`else
      m_sop   <= check_d1 && (addr_d1 == P_LAST);
`endif
    end
  end

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Testbench for ldpc_enc_ctrl: behavioural encoder + golden parity from accepted bits.
// Frames: all-zero, single one, random with gaps, mid-frame abort, reset mid-PARITY.
// Define LDPC_SYS_OUT_EN for the systematic-output build.
module tb_ldpc_enc_ctrl;

  localparam int K = 4320;
  localparam int P = 360;
`ifdef LDPC_SYS_OUT_EN
  localparam int N_OUT = K + P;
  localparam int OFF   = K;
`else
  localparam int N_OUT = P;
  localparam int OFF   = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_data = 1'b0;
  logic        s_sop = 1'b0;
  logic        s_ready;
  logic        enc_rst_n;
  logic        enc_din_valid;
  logic        enc_din;
  logic [12:0] enc_counter;
  logic [8:0]  enc_out_addr;
  logic        enc_check;
  logic        enc_dout = 1'b0;
  logic        m_valid, m_data, m_sop, m_eop;
  logic        busy, frame_err;

  ldpc_enc_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop), .s_ready(s_ready),
    .enc_rst_n(enc_rst_n), .enc_din_valid(enc_din_valid), .enc_din(enc_din),
    .enc_counter(enc_counter), .enc_out_addr(enc_out_addr), .enc_check(enc_check),
    .enc_dout(enc_dout),
    .m_valid(m_valid), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Quasi-cyclic parity taps: group g, tap j, offset within group.
  function automatic int tap(input int g, input int j, input int off);
    return (g * 37 + j * 113 + 7 + off) % P;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Encoder model: accumulates on enc_counter, registered read one cycle after address.
  bit par[P];
  always @(posedge clk) begin
    if (!enc_rst_n) begin
      foreach (par[i]) par[i] = 1'b0;
    end else begin
      if (enc_din_valid && enc_din) begin
        for (int j = 0; j < 3; j++) begin
          int a;
          a = tap(int'(enc_counter) / P, j, int'(enc_counter) % P);
          par[a] = !par[a];
        end
      end
      if (enc_check) enc_dout <= par[enc_out_addr];
    end
  end

  // Observation state.
  bit         acc_q[$];
  logic [2:0] out_q[$];  // {sop, eop, data}
  int ferr_cnt = 0, clr_cnt = 0;
  int din_idx = 0, prev_cnt = 0, din_first = 0, din_last = 0;
  int last_acc_edge = 0, par_edge = 0;

  // Monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      din_idx  = 0;
      prev_cnt = 0;
    end else begin
      if (s_valid && s_ready) begin
        acc_q.push_back(s_data);
        last_acc_edge = cyc + 1;
      end
      if (m_valid) begin
        out_q.push_back({m_sop, m_eop, m_data});
        if (par_edge == 0 && cyc > last_acc_edge) par_edge = cyc;
      end
      if (frame_err) ferr_cnt++;
      if (!enc_rst_n) begin
        clr_cnt++;
        chk("clear_counter", enc_counter, 0);
        din_idx  = 0;
        prev_cnt = 0;
      end else if (enc_din_valid) begin
        chk("din_counter", enc_counter, din_idx);
        if (din_idx == 0) din_first = cyc;
        din_last = cyc;
        din_idx++;
        prev_cnt = int'(enc_counter);
      end else begin
        chk("counter_hold", enc_counter, prev_cnt);
      end
    end
  end

  task automatic push_bit(input logic d, input logic sop);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sop   = sop;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_data  = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit gaps, input int nbits);
    acc_q.delete();
    out_q.delete();
    ferr_cnt = 0;
    clr_cnt  = 0;
    par_edge = 0;
    for (int i = 0; i < nbits; i++) begin
      logic d;
      int   g;
      g = 0;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1 && g < 4) begin
          @(posedge clk);
          #1;
          g++;
        end
      end
      case (mode)
        0:       d = 1'b0;
        1:       d = (i == 0);
        default: d = 1'($urandom_range(0, 1));
      endcase
      push_bit(d, i == 0);
    end
  endtask

  task automatic verify_frame(input string tag, input int exp_ferr, input bit contig, input bit one_hot);
    bit gp[P];
    int t, n, nmis, nsop, neop, ones;
    logic e;
    t = 0;
    while (out_q.size() < N_OUT && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_out_len"}, out_q.size(), N_OUT);
    chk({tag, "_acc_len"}, acc_q.size(), K);
    foreach (gp[i]) gp[i] = 1'b0;
    for (int i = 0; i < acc_q.size(); i++)
      if (acc_q[i])
        for (int j = 0; j < 3; j++) gp[tap(i / P, j, i % P)] ^= 1'b1;
    n = (out_q.size() < N_OUT) ? out_q.size() : N_OUT;
    nmis = 0; nsop = 0; neop = 0; ones = 0;
    for (int k = 0; k < n; k++) begin
      if (k < OFF) e = (k < acc_q.size()) ? acc_q[k] : 1'b0;
      else         e = gp[P - 1 - (k - OFF)];
      if (out_q[k][0] != e) nmis++;
      if (k >= OFF && out_q[k][0]) ones++;
      nsop += int'(out_q[k][2]);
      neop += int'(out_q[k][1]);
    end
    chk({tag, "_data_mismatches"}, nmis, 0);
    chk({tag, "_sop_count"}, nsop, 1);
    chk({tag, "_eop_count"}, neop, 1);
    if (n > 0) begin
      chk({tag, "_sop_first"}, out_q[0][2], 1);
      chk({tag, "_eop_last"}, out_q[n-1][1], 1);
    end
    chk({tag, "_frame_err"}, ferr_cnt, exp_ferr);
    chk({tag, "_clear_cycles"}, clr_cnt, 3);
    chk({tag, "_latency"}, par_edge - last_acc_edge, 4);
    if (contig) chk({tag, "_din_contig"}, din_last - din_first + 1, K);
    if (one_hot && n == N_OUT) begin
      chk({tag, "_ones"}, ones, 3);
      chk({tag, "_row_7"},   out_q[OFF + P - 1 - 7][0],   1);
      chk({tag, "_row_120"}, out_q[OFF + P - 1 - 120][0], 1);
      chk({tag, "_row_233"}, out_q[OFF + P - 1 - 233][0], 1);
    end
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_enc_rst_n", enc_rst_n, 1);
    chk("rst_counter", enc_counter, 0);
    chk("rst_out_addr", enc_out_addr, P - 1);
    chk("rst_din_valid", enc_din_valid, 0);
    chk("rst_check", enc_check, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 1'b0, K);
    verify_frame("zero", 0, 1'b1, 1'b0);

    run_frame(1, 1'b0, K);
    verify_frame("single", 0, 1'b1, 1'b1);

    run_frame(2, 1'b1, K);
    verify_frame("rand_gap", 0, 1'b0, 1'b0);

    run_frame(2, 1'b0, 1000);
    repeat (3) @(posedge clk);
    #1;
    run_frame(2, 1'b0, K);
    verify_frame("after_abort", 1, 1'b1, 1'b0);

    run_frame(2, 1'b0, K);
    t = 0;
    while (!enc_check && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_parity", enc_check, 1);
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_enc_rst_n", enc_rst_n, 1);
    chk("midrst_counter", enc_counter, 0);
    chk("midrst_check", enc_check, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_q.delete();
    repeat (600) @(posedge clk);
    #1;
    chk("postrst_no_output", out_q.size(), 0);
    chk("postrst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
